// File: rtl/pwm_multi_duty.sv
// Multi-channel PWM generator. All channels share one frame counter, and duty updates are double-buffered.
// The optional ramp behaviour is enabled with the PWM_FADE_EN macro: active duty steps by one per frame toward the target.
module pwm_multi_duty #(
  parameter int CHANNELS = 4,
  parameter int PERIOD   = 5000000,
  parameter int DUTY_MAX = 100,
  parameter int DUTY_W   = 7,
  parameter int CNT_W    = 23
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [CHANNELS-1:0]        enable,
  input  logic [CHANNELS*DUTY_W-1:0] dutyIn,
  input  logic [CHANNELS-1:0]        dutyLoad,
  output logic [CHANNELS-1:0]        pwmOut,
  output logic [CHANNELS-1:0]        pending,
  output logic                       frameStart
);

  localparam int                PROD_W = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  STEP   = CNT_W'(PERIOD / DUTY_MAX);
  localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(DUTY_MAX);

  logic [CNT_W-1:0] count;
  logic             boundary;
  logic             frame_start;

  assign boundary   = (count == LAST);
  assign frameStart = frame_start;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count       <= '0;
      frame_start <= 1'b0;
    end else begin
      count       <= boundary ? '0 : count + 1'b1;
      frame_start <= boundary;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DUTY_W-1:0] raw;
    logic [DUTY_W-1:0] clamped;
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] active;
    logic [DUTY_W-1:0] step_next;
    logic [PROD_W-1:0] thr;
    logic              pend;
    logic              pwm;

    assign raw     = dutyIn[i*DUTY_W +: DUTY_W];
    assign clamped = (raw > DMAX) ? DMAX : raw;
    // Full-width product so large PERIOD values never wrap the threshold.
    assign thr     = PROD_W'(active) * PROD_W'(STEP);

`ifdef PWM_FADE_EN
    always_comb begin
      step_next = active;
      if (active < shadow)
        step_next = active + 1'b1;
      else if (active > shadow)
        step_next = active - 1'b1;
    end
`else
    assign step_next = shadow;
`endif

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        shadow <= '0;
        active <= '0;
        pend   <= 1'b0;
        pwm    <= 1'b0;
      end else begin
        pwm <= enable[i] && (PROD_W'(count) < thr);
        if (boundary && pend) begin
          active <= step_next;
          if (step_next == shadow)
            pend <= 1'b0;
        end
        // A load on the boundary edge wins over the clear and is applied one frame later.
        if (dutyLoad[i]) begin
          shadow <= clamped;
          pend   <= 1'b1;
        end
      end
    end

    assign pending[i] = pend;
    assign pwmOut[i]  = pwm;
  end

endmodule

// File: tb/tb_pwm_multi_duty.sv
// Self-checking bench for pwm_multi_duty. Each measured frame's expected widths and pending state are queued when stimulus is driven, then popped and compared at frameStart.
// Width codes: n = n-clock high prefix; 1000+n = n highs not forming a single leading run.
module tb_pwm_multi_duty;
  localparam int CH   = 4;
  localparam int PER  = 200;
  localparam int DMAX = 100;
  localparam int DW   = 7;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              resetN;
  logic [CH-1:0]     enable;
  logic [CH*DW-1:0]  dutyIn;
  logic [CH-1:0]     dutyLoad;
  logic [CH-1:0]     pwmOut;
  logic [CH-1:0]     pending;
  logic              frameStart;

  pwm_multi_duty #(
    .CHANNELS(CH), .PERIOD(PER), .DUTY_MAX(DMAX), .DUTY_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .dutyIn(dutyIn),
    .dutyLoad(dutyLoad), .pwmOut(pwmOut), .pending(pending), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [3:0]       pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic sync();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frameStart && k < 500);
    if (!frameStart) chk("sync_timeout", k, PER);
    #1;
  endtask

  task automatic push(input int w0, input int w1, input int w2, input int w3, input logic [3:0] p);
    exp_t e;
    e.w[0] = 16'(w0);
    e.w[1] = 16'(w1);
    e.w[2] = 16'(w2);
    e.w[3] = 16'(w3);
    e.pend = p;
    sb.push_back(e);
  endtask

  task automatic load(input int ch, input int val);
    dutyIn[ch*DW +: DW] = DW'(val);
    dutyLoad = CH'(1 << ch);
    step(1);
    dutyLoad = '0;
  endtask

  task automatic count_to_frame(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frameStart && k < 500);
    chk(tag, k, PER);
    #1;
  endtask

  // Output monitor: one sample per cycle; sample j reflects counter value j of the frame.
  int hi [CH];
  int first_low [CH];
  int len;
  int frame_no = 0;

  initial begin
    exp_t e;
    int   code;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        len = 0;
        for (int i = 0; i < CH; i++) begin
          hi[i] = 0;
          first_low[i] = -1;
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (pwmOut[i]) hi[i]++;
          else if (first_low[i] < 0) first_low[i] = len;
        end
        len++;
        if (frameStart) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            frame_no++;
            chk($sformatf("f%0d_len", frame_no), len, PER);
            for (int i = 0; i < CH; i++) begin
              code = (first_low[i] < 0 || hi[i] == first_low[i]) ? hi[i] : 1000 + hi[i];
              chk($sformatf("f%0d_ch%0d_width", frame_no, i), code, 32'(e.w[i]));
            end
            chk($sformatf("f%0d_pending", frame_no), 32'(pending), 32'(e.pend));
          end
          len = 0;
          for (int i = 0; i < CH; i++) begin
            hi[i] = 0;
            first_low[i] = -1;
          end
        end
      end
    end
  end

  initial begin
    resetN   = 1'b0;
    enable   = '0;
    dutyIn   = '0;
    dutyLoad = '0;
    step(2);
    chk("rst_pwm", 32'(pwmOut), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fs", 32'(frameStart), 0);
    resetN = 1'b1;
    count_to_frame("first_frame_len");

`ifdef PWM_FADE_EN
    push(0, 0, 0, 0, 4'b0001);
    enable = 4'b0001;
    load(0, 3);
    sync();
    push(2, 0, 0, 0, 4'b0001);
    sync();
    push(4, 0, 0, 0, 4'b0000);
    sync();
    push(6, 0, 0, 0, 4'b0000);
    sync();
`else
    push(0, 0, 0, 0, 4'b0000);
    enable = 4'b0001;
    load(0, 25);
    chk("pend_after_load", 32'(pending), 32'(4'b0001));
    sync();

    push(50, 0, 0, 0, 4'b0000);
    enable = 4'b0111;
    load(1, 0);
    load(2, 100);
    chk("pend_ch12", 32'(pending), 32'(4'b0110));
    sync();

    push(50, 0, 200, 0, 4'b0000);
    sync();

    push(50, 0, 200, 0, 4'b0000);
    step(100);
    load(0, 60);
    chk("pend_midframe", 32'(pending), 32'(4'b0001));
    sync();

    push(120, 0, 200, 0, 4'b0000);
    enable = 4'b1111;
    load(3, 127);
    sync();

    // Two loads in one frame (last wins), then a third exactly on the boundary edge.
    push(120, 0, 200, 200, 4'b0001);
    load(0, 90);
    step(49);
    load(0, 25);
    step(148);
    dutyIn[0 +: DW] = DW'(10);
    dutyLoad = 4'b0001;
    @(negedge clk);
    chk("boundary_fs", 32'(frameStart), 1);
    #1;
    dutyLoad = '0;

    push(1030, 0, 200, 200, 4'b0000);
    step(10);
    enable[0] = 1'b0;
    step(20);
    enable[0] = 1'b1;
    sync();

    push(20, 0, 200, 200, 4'b0000);
    sync();

    load(1, 50);
    chk("pend_before_rst", 32'(pending), 32'(4'b0010));
    step(99);
    resetN = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwmOut), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_fs", 32'(frameStart), 0);
    step(3);
    resetN = 1'b1;
    push(0, 0, 0, 0, 4'b0000);
    count_to_frame("restart_len");

    push(0, 0, 0, 0, 4'b0000);
    load(0, 50);
    sync();

    push(100, 0, 0, 0, 4'b0000);
    sync();
`endif

    step(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
